// File: rtl/rv32im_br_pred.sv
// ---------------------------------------------------------------------------
// rv32im_br_pred
// Branch prediction and resolution unit for the rv32im core.
//
// Fetch side: a direct-mapped branch target buffer with 2-bit saturating
// counters gives a same-cycle prediction for fetch_pc_i.
// Execute side: resolves conditional branches from the EXU compare flags
// and unconditional jumps. Mispredictions produce a registered redirect one
// cycle later, and the table is trained on that same edge.
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   fetch_pc_i            PC being fetched
//   pred_taken_o          predicted taken for fetch_pc_i (combinational)
//   pred_pc_o             predicted next PC (combinational)
//   res_valid_i           resolve request this cycle
//   res_pc_i              PC of the resolving branch/jump
//   res_conditional_i     1 = conditional branch, 0 = JAL/JALR
//   res_funct3_i          branch funct3
//   res_eq_i/lt_i/ltu_i   compare flags from the EXU
//   res_target_i          computed taken target
//   res_pred_taken_i      prediction carried with the instruction
//   res_pred_pc_i         predicted next PC carried with the instruction
//   redirect_o            registered flush/refetch request
//   redirect_pc_o         registered correct next PC
//   br_cnt_o              accepted resolves (wraps)
//   mispred_cnt_o         accepted mispredictions (wraps)
// ---------------------------------------------------------------------------
`ifndef API_ADDR_WIDTH
`define API_ADDR_WIDTH 32
`endif

module rv32im_br_pred #(
  parameter int ADDR_WIDTH = `API_ADDR_WIDTH,
  parameter int BTB_DEPTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [ADDR_WIDTH-1:0] fetch_pc_i,
  output logic                  pred_taken_o,
  output logic [ADDR_WIDTH-1:0] pred_pc_o,
  input  logic                  res_valid_i,
  input  logic [ADDR_WIDTH-1:0] res_pc_i,
  input  logic                  res_conditional_i,
  input  logic [2:0]            res_funct3_i,
  input  logic                  res_eq_i,
  input  logic                  res_lt_i,
  input  logic                  res_ltu_i,
  input  logic [ADDR_WIDTH-1:0] res_target_i,
  input  logic                  res_pred_taken_i,
  input  logic [ADDR_WIDTH-1:0] res_pred_pc_i,
  output logic                  redirect_o,
  output logic [ADDR_WIDTH-1:0] redirect_pc_o,
  output logic [31:0]           br_cnt_o,
  output logic [31:0]           mispred_cnt_o
);

  localparam int IDX_W = $clog2(BTB_DEPTH);
  localparam int TAG_W = ADDR_WIDTH - IDX_W - 2;
  localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(4);

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // BTB storage, one flop array per field so reset can clear every entry.
  logic                  btbValid_q  [BTB_DEPTH];
  logic                  btbUncond_q [BTB_DEPTH];
  logic [TAG_W-1:0]      btbTag_q    [BTB_DEPTH];
  logic [ADDR_WIDTH-1:0] btbTarget_q [BTB_DEPTH];
  logic [1:0]            btbCtr_q    [BTB_DEPTH];

  logic                  redirect_q;
  logic [ADDR_WIDTH-1:0] redirectPc_q;
  logic [31:0]           brCnt_q;
  logic [31:0]           misCnt_q;

  // Fetch-side lookup. Reads the current table contents only, so a write
  // to the same index in this cycle is not visible until the next one.
  logic [IDX_W-1:0]      lkIdx;
  logic [TAG_W-1:0]      lkTag;
  logic                  lkHit;
  logic [ADDR_WIDTH-1:0] lkPcPlus4;

  assign lkIdx     = fetch_pc_i[IDX_W+1:2];
  assign lkTag     = fetch_pc_i[ADDR_WIDTH-1:IDX_W+2];
  assign lkHit     = btbValid_q[lkIdx] && (btbTag_q[lkIdx] == lkTag);
  assign lkPcPlus4 = fetch_pc_i + PC_STEP;

  assign pred_taken_o = lkHit && (btbUncond_q[lkIdx] || btbCtr_q[lkIdx][1]);
  assign pred_pc_o    = pred_taken_o ? btbTarget_q[lkIdx] : lkPcPlus4;

  // Resolve side: actual direction, correct next PC and mispredict flag.
  // Reserved funct3 values (010/011) resolve not-taken and never train.
  logic                  resTaken;
  logic                  resKnown;
  logic [ADDR_WIDTH-1:0] resActualPc;
  logic                  resMispredict;
  logic                  resAccepted;
  logic [IDX_W-1:0]      resIdx;
  logic [TAG_W-1:0]      resTag;
  logic                  resHit;

  assign resIdx = res_pc_i[IDX_W+1:2];
  assign resTag = res_pc_i[ADDR_WIDTH-1:IDX_W+2];
  assign resHit = btbValid_q[resIdx] && (btbTag_q[resIdx] == resTag);

  always_comb begin
    resTaken = 1'b0;
    resKnown = 1'b1;
    if (!res_conditional_i) begin
      resTaken = 1'b1;
    end else begin
      case (res_funct3_i)
        F3_BEQ:  resTaken = res_eq_i;
        F3_BNE:  resTaken = !res_eq_i;
        F3_BLT:  resTaken = res_lt_i;
        F3_BGE:  resTaken = !res_lt_i;
        F3_BLTU: resTaken = res_ltu_i;
        F3_BGEU: resTaken = !res_ltu_i;
        default: resKnown = 1'b0;
      endcase
    end
  end

  assign resActualPc   = resTaken ? res_target_i : (res_pc_i + PC_STEP);
  assign resMispredict = (res_pred_taken_i != resTaken) ||
                         (resTaken && (res_pred_pc_i != res_target_i));

  // While a redirect is out, the instruction resolving now is on the wrong
  // path and must leave no trace.
  assign resAccepted = res_valid_i && !redirect_q;

  // Training: build the new contents of the entry at resIdx.
  logic                  wrEn_d;
  logic                  wrUncond_d;
  logic [1:0]            wrCtr_d;
  logic [ADDR_WIDTH-1:0] wrTarget_d;

  always_comb begin
    wrEn_d     = 1'b0;
    wrUncond_d = btbUncond_q[resIdx];
    wrCtr_d    = btbCtr_q[resIdx];
    wrTarget_d = btbTarget_q[resIdx];
    if (resAccepted && resKnown) begin
      if (!res_conditional_i) begin
        wrEn_d     = 1'b1;
        wrUncond_d = 1'b1;
        wrCtr_d    = 2'b11;
        wrTarget_d = res_target_i;
      end else if (resTaken) begin
        wrEn_d     = 1'b1;
        wrTarget_d = res_target_i;
        if (resHit) begin
          wrCtr_d = (btbCtr_q[resIdx] == 2'b11) ? 2'b11 : btbCtr_q[resIdx] + 2'b01;
        end else begin
          wrUncond_d = 1'b0;
          wrCtr_d    = 2'b10;
        end
      end else if (resHit) begin
        wrEn_d  = 1'b1;
        wrCtr_d = (btbCtr_q[resIdx] == 2'b00) ? 2'b00 : btbCtr_q[resIdx] - 2'b01;
      end
    end
  end

  // Table update; reset leaves every entry invalid, weakly not-taken.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < BTB_DEPTH; i++) begin
        btbValid_q[i]  <= 1'b0;
        btbUncond_q[i] <= 1'b0;
        btbTag_q[i]    <= '0;
        btbTarget_q[i] <= '0;
        btbCtr_q[i]    <= 2'b01;
      end
    end else if (wrEn_d) begin
      btbValid_q[resIdx]  <= 1'b1;
      btbUncond_q[resIdx] <= wrUncond_d;
      btbTag_q[resIdx]    <= resTag;
      btbTarget_q[resIdx] <= wrTarget_d;
      btbCtr_q[resIdx]    <= wrCtr_d;
    end
  end

  // Redirect and statistics, registered on the same edge as training.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      redirect_q   <= 1'b0;
      redirectPc_q <= '0;
      brCnt_q      <= '0;
      misCnt_q     <= '0;
    end else begin
      redirect_q <= resAccepted && resMispredict;
      if (resAccepted && resMispredict) begin
        redirectPc_q <= resActualPc;
      end
      if (resAccepted) begin
        brCnt_q <= brCnt_q + 32'd1;
      end
      if (resAccepted && resMispredict) begin
        misCnt_q <= misCnt_q + 32'd1;
      end
    end
  end

  assign redirect_o    = redirect_q;
  assign redirect_pc_o = redirectPc_q;
  assign br_cnt_o      = brCnt_q;
  assign mispred_cnt_o = misCnt_q;

endmodule

// File: tb/tb_rv32im_br_pred.sv
// ---------------------------------------------------------------------------
// tb_rv32im_br_pred
// Directed bench for rv32im_br_pred with default parameters (32-bit PC,
// 16-entry BTB: index pc[5:2], tag pc[31:6]). A table of resolve vectors,
// each followed by a lookup, plus hand-written sequences for reset,
// redirect kill, back-to-back resolves and reset during a redirect.
// ---------------------------------------------------------------------------
module tb_rv32im_br_pred;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic [31:0] fetch_pc_i = '0;
  logic        pred_taken_o;
  logic [31:0] pred_pc_o;
  logic        res_valid_i = 1'b0;
  logic [31:0] res_pc_i = '0;
  logic        res_conditional_i = 1'b0;
  logic [2:0]  res_funct3_i = '0;
  logic        res_eq_i = 1'b0;
  logic        res_lt_i = 1'b0;
  logic        res_ltu_i = 1'b0;
  logic [31:0] res_target_i = '0;
  logic        res_pred_taken_i = 1'b0;
  logic [31:0] res_pred_pc_i = '0;
  logic        redirect_o;
  logic [31:0] redirect_pc_o;
  logic [31:0] br_cnt_o;
  logic [31:0] mispred_cnt_o;

  int checks = 0;
  int errors = 0;
  int expBr  = 0;
  int expMis = 0;

  rv32im_br_pred dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .fetch_pc_i        (fetch_pc_i),
    .pred_taken_o      (pred_taken_o),
    .pred_pc_o         (pred_pc_o),
    .res_valid_i       (res_valid_i),
    .res_pc_i          (res_pc_i),
    .res_conditional_i (res_conditional_i),
    .res_funct3_i      (res_funct3_i),
    .res_eq_i          (res_eq_i),
    .res_lt_i          (res_lt_i),
    .res_ltu_i         (res_ltu_i),
    .res_target_i      (res_target_i),
    .res_pred_taken_i  (res_pred_taken_i),
    .res_pred_pc_i     (res_pred_pc_i),
    .redirect_o        (redirect_o),
    .redirect_pc_o     (redirect_pc_o),
    .br_cnt_o          (br_cnt_o),
    .mispred_cnt_o     (mispred_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] pc;
    logic        cond;
    logic [2:0]  f3;
    logic        eq;
    logic        lt;
    logic        ltu;
    logic [31:0] target;
    logic        predTaken;
    logic [31:0] predPc;
    logic        expRedirect;
    logic [31:0] expRedirectPc;
    logic [31:0] lookPc;
    logic        expPredTaken;
    logic [31:0] expPredPc;
  } vec_t;

  vec_t vecs[$];

  task automatic addVec(input logic [31:0] pc, input logic cond, input logic [2:0] f3,
                        input logic eq, input logic lt, input logic ltu,
                        input logic [31:0] target, input logic predTaken,
                        input logic [31:0] predPc, input logic expRedirect,
                        input logic [31:0] expRedirectPc, input logic [31:0] lookPc,
                        input logic expPredTaken, input logic [31:0] expPredPc);
    vec_t v;
    v.pc = pc; v.cond = cond; v.f3 = f3; v.eq = eq; v.lt = lt; v.ltu = ltu;
    v.target = target; v.predTaken = predTaken; v.predPc = predPc;
    v.expRedirect = expRedirect; v.expRedirectPc = expRedirectPc;
    v.lookPc = lookPc; v.expPredTaken = expPredTaken; v.expPredPc = expPredPc;
    vecs.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic driveResolve(input logic [31:0] pc, input logic cond, input logic [2:0] f3,
                              input logic eq, input logic lt, input logic ltu,
                              input logic [31:0] target, input logic predTaken,
                              input logic [31:0] predPc);
    res_valid_i       = 1'b1;
    res_pc_i          = pc;
    res_conditional_i = cond;
    res_funct3_i      = f3;
    res_eq_i          = eq;
    res_lt_i          = lt;
    res_ltu_i         = ltu;
    res_target_i      = target;
    res_pred_taken_i  = predTaken;
    res_pred_pc_i     = predPc;
  endtask

  task automatic applyStimulus(input vec_t v);
    driveResolve(v.pc, v.cond, v.f3, v.eq, v.lt, v.ltu, v.target, v.predTaken, v.predPc);
    tick();
    res_valid_i = 1'b0;
  endtask

  task automatic checkLookup(input string name, input logic [31:0] pc,
                             input logic expTaken, input logic [31:0] expPc);
    fetch_pc_i = pc;
    #1;
    checkOutput({name, ".pred_taken"}, {31'd0, pred_taken_o}, {31'd0, expTaken});
    checkOutput({name, ".pred_pc"}, pred_pc_o, expPc);
  endtask

  initial begin
    // Resolve vectors with their follow-up lookup.
    // pc, cond, f3, eq, lt, ltu, target, predTaken, predPc,
    // expRedirect, expRedirectPc, lookPc, expPredTaken, expPredPc
    addVec(32'h200, 1, 3'b000, 1, 0, 0, 32'h180, 0, 32'h204, 1, 32'h180, 32'h200, 1, 32'h180);
    addVec(32'h040, 1, 3'b001, 0, 0, 0, 32'h020, 0, 32'h044, 1, 32'h020, 32'h040, 1, 32'h020);
    addVec(32'h040, 1, 3'b001, 0, 0, 0, 32'h020, 1, 32'h020, 0, 32'h000, 32'h040, 1, 32'h020);
    addVec(32'h040, 1, 3'b001, 0, 0, 0, 32'h020, 1, 32'h020, 0, 32'h000, 32'h040, 1, 32'h020);
    addVec(32'h040, 1, 3'b001, 1, 0, 0, 32'h020, 1, 32'h020, 1, 32'h044, 32'h040, 1, 32'h020);
    addVec(32'h040, 1, 3'b001, 1, 0, 0, 32'h020, 1, 32'h020, 1, 32'h044, 32'h040, 0, 32'h044);
    addVec(32'h080, 1, 3'b000, 0, 1, 0, 32'h090, 0, 32'h084, 0, 32'h000, 32'h080, 0, 32'h084);
    addVec(32'h080, 1, 3'b101, 0, 1, 0, 32'h090, 0, 32'h084, 0, 32'h000, 32'h080, 0, 32'h084);
    addVec(32'h080, 1, 3'b110, 0, 1, 0, 32'h090, 0, 32'h084, 0, 32'h000, 32'h080, 0, 32'h084);
    addVec(32'h080, 1, 3'b010, 0, 1, 0, 32'h090, 0, 32'h084, 0, 32'h000, 32'h080, 0, 32'h084);
    addVec(32'h080, 1, 3'b001, 0, 1, 0, 32'h090, 0, 32'h084, 1, 32'h090, 32'h080, 1, 32'h090);
    addVec(32'h080, 1, 3'b100, 0, 1, 0, 32'h090, 0, 32'h084, 1, 32'h090, 32'h080, 1, 32'h090);
    addVec(32'h080, 1, 3'b111, 0, 1, 0, 32'h090, 0, 32'h084, 1, 32'h090, 32'h080, 1, 32'h090);
    addVec(32'h080, 1, 3'b010, 0, 1, 0, 32'h090, 0, 32'h084, 0, 32'h000, 32'h080, 1, 32'h090);
    addVec(32'h080, 1, 3'b011, 0, 1, 0, 32'h090, 0, 32'h084, 0, 32'h000, 32'h080, 1, 32'h090);
    addVec(32'h300, 0, 3'b000, 0, 0, 0, 32'h1000, 0, 32'h304, 1, 32'h1000, 32'h300, 1, 32'h1000);
    addVec(32'h300, 0, 3'b000, 0, 0, 0, 32'h1000, 1, 32'h1000, 0, 32'h000, 32'h340, 0, 32'h344);
    addVec(32'h300, 0, 3'b000, 0, 0, 0, 32'h2000, 1, 32'h1000, 1, 32'h2000, 32'h300, 1, 32'h2000);
    addVec(32'h1234, 1, 3'b110, 0, 0, 1, 32'h1000, 0, 32'h1238, 1, 32'h1000, 32'h1234, 1, 32'h1000);

    // Reset and reset-state checks.
    #1 rst_i = 1'b1;
    tick();
    tick();
    checkLookup("rst_lookup_100", 32'h100, 1'b0, 32'h104);
    rst_i = 1'b0;
    tick();
    checkLookup("rst_lookup_wrap", 32'hFFFF_FFFC, 1'b0, 32'h0);
    checkOutput("rst_redirect", {31'd0, redirect_o}, 32'd0);
    checkOutput("rst_redirect_pc", redirect_pc_o, 32'd0);
    checkOutput("rst_br_cnt", br_cnt_o, 32'd0);
    checkOutput("rst_mispred_cnt", mispred_cnt_o, 32'd0);

    // Table-driven resolves, each with an idle cycle then a lookup.
    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      expBr++;
      if (vecs[i].expRedirect) expMis++;
      checkOutput($sformatf("v%0d.redirect", i), {31'd0, redirect_o}, {31'd0, vecs[i].expRedirect});
      if (vecs[i].expRedirect)
        checkOutput($sformatf("v%0d.redirect_pc", i), redirect_pc_o, vecs[i].expRedirectPc);
      checkOutput($sformatf("v%0d.br_cnt", i), br_cnt_o, 32'(expBr));
      checkOutput($sformatf("v%0d.mispred_cnt", i), mispred_cnt_o, 32'(expMis));
      tick();
      checkOutput($sformatf("v%0d.redirect_drop", i), {31'd0, redirect_o}, 32'd0);
      checkLookup($sformatf("v%0d.lookup", i), vecs[i].lookPc, vecs[i].expPredTaken, vecs[i].expPredPc);
    end

    // Wrong-path resolve right behind a redirect is discarded.
    driveResolve(32'h500, 1, 3'b000, 1, 0, 0, 32'h600, 0, 32'h504);
    tick();
    expBr++;
    expMis++;
    checkOutput("kill.first_redirect", {31'd0, redirect_o}, 32'd1);
    checkOutput("kill.first_redirect_pc", redirect_pc_o, 32'h600);
    driveResolve(32'h700, 0, 3'b000, 0, 0, 0, 32'h800, 0, 32'h704);
    tick();
    res_valid_i = 1'b0;
    checkOutput("kill.no_second_redirect", {31'd0, redirect_o}, 32'd0);
    checkOutput("kill.br_cnt", br_cnt_o, 32'(expBr));
    checkOutput("kill.mispred_cnt", mispred_cnt_o, 32'(expMis));
    checkLookup("kill.no_train", 32'h700, 1'b0, 32'h704);
    checkLookup("kill.first_trained", 32'h500, 1'b1, 32'h600);

    // Back-to-back correctly predicted resolves are both accepted.
    driveResolve(32'h900, 1, 3'b000, 0, 0, 0, 32'h950, 0, 32'h904);
    tick();
    checkOutput("b2b.redirect1", {31'd0, redirect_o}, 32'd0);
    tick();
    res_valid_i = 1'b0;
    expBr += 2;
    checkOutput("b2b.redirect2", {31'd0, redirect_o}, 32'd0);
    checkOutput("b2b.br_cnt", br_cnt_o, 32'(expBr));
    checkOutput("b2b.mispred_cnt", mispred_cnt_o, 32'(expMis));

    // Reset asserted while a redirect is being presented.
    fetch_pc_i = 32'h500;
    driveResolve(32'h500, 1, 3'b000, 1, 0, 0, 32'h600, 0, 32'h504);
    tick();
    res_valid_i = 1'b0;
    checkOutput("midrst.redirect_before", {31'd0, redirect_o}, 32'd1);
    #1 rst_i = 1'b1;
    #1;
    checkOutput("midrst.redirect", {31'd0, redirect_o}, 32'd0);
    checkOutput("midrst.redirect_pc", redirect_pc_o, 32'd0);
    checkOutput("midrst.br_cnt", br_cnt_o, 32'd0);
    checkOutput("midrst.mispred_cnt", mispred_cnt_o, 32'd0);
    checkLookup("midrst.lookup", 32'h500, 1'b0, 32'h504);
    tick();
    rst_i = 1'b0;
    tick();
    checkOutput("postrst.redirect", {31'd0, redirect_o}, 32'd0);
    checkLookup("postrst.lookup", 32'h200, 1'b0, 32'h204);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
